dir_ctrl: RTL and testbench
===========================

DIR_CTRL -- requirements
Module: dir_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-stable cycles needed to accept a press or release; legal range is 2 or more.
REQ-002 Parameter INIT_UP, default 1'b0: value of up after reset.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port btn_raw, input, 1: asynchronous, bouncy push-button level; 1 means pressed.
REQ-006 Port en, input, 1: synchronous toggle enable.
REQ-007 Port up, output, 1: registered direction level; drives the up input of the fsm counter block.
REQ-008 Port press_pulse, output, 1: registered one-cycle strobe per accepted press that toggled up.

Function
REQ-009 btn_raw SHALL pass through a two-flop synchronizer; the FSM sees only the synchronized value btn_s.
REQ-010 States SHALL be exactly IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with a debounce counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 In IDLE, btn_s=1 SHALL go to PRESS_WAIT with cnt=1; otherwise the FSM stays in IDLE with cnt=0.
REQ-012 In PRESS_WAIT, btn_s=0 SHALL return to IDLE with cnt=0.
REQ-013 In PRESS_WAIT, btn_s=1 with cnt<DEBOUNCE_CYCLES SHALL increment cnt.
REQ-014 The edge on which cnt reaches DEBOUNCE_CYCLES SHALL enter PRESSED (the acceptance edge).
REQ-015 On the acceptance edge with en=1, up SHALL invert on that same edge, and press_pulse SHALL be 1 for exactly the following cycle.
REQ-016 On the acceptance edge with en=0, up SHALL hold and press_pulse SHALL stay 0; en is sampled only on the acceptance edge.
REQ-017 Latency: with btn_raw stable high, call the first edge that samples it high edge 1; the acceptance edge SHALL then be edge DEBOUNCE_CYCLES+2 (edge 6 at the default).
REQ-018 In PRESSED, btn_s=0 SHALL go to RELEASE_WAIT with cnt=1.
REQ-019 In RELEASE_WAIT, btn_s=1 SHALL return to PRESSED with cnt=0, and SHALL NOT toggle up.
REQ-020 In RELEASE_WAIT, btn_s=0 SHALL increment cnt; reaching DEBOUNCE_CYCLES SHALL go to IDLE with no output change.
REQ-021 Release SHALL never toggle up; at most one toggle per debounced press.
REQ-022 cnt SHALL saturate and never wrap; unused state encodings SHALL recover to IDLE on the next edge.
REQ-023 press_pulse SHALL never be asserted on two consecutive cycles.

Reset
REQ-024 While reset=0 at a rising edge: synchronizer flops=0, state=IDLE, cnt=0, up=INIT_UP, press_pulse=0.
REQ-025 Reset SHALL override all other inputs, including the acceptance edge.
REQ-026 Reset asserted mid-press SHALL abort the press; a button still held at reset release SHALL be treated as a new press and accepted per REQ-017.

Structure
REQ-027 Package dir_ctrl_pkg SHALL hold the state enum typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the default DEBOUNCE_CYCLES constant.
REQ-028 The two-flop synchronizer SHALL be a separate sub-module named sync2 (1-bit, reset-to-0); all other logic stays in dir_ctrl.

Verification (DEBOUNCE_CYCLES=4, INIT_UP=0)
REQ-029 Reset test: reset=0 for 2 edges with btn_raw=0 -> up=0, press_pulse=0, state IDLE; then 10 idle edges -> outputs unchanged.
REQ-030 Clean press: btn_raw=1 from edge 1 for 12 edges, then 0 for 12 edges, en=1 -> up 0->1 at edge 6; press_pulse=1 only in the cycle after edge 6; up stays 1 through release.
REQ-031 Press bounce: btn_raw alternates 1 for 3 edges / 0 for 1 edge, five times -> up stays 0 and press_pulse is never 1.
REQ-032 Release bounce: from PRESSED with up=1, btn_raw=0 for 2 edges, then 1 for 5, then 0 for 12 -> up stays 1, no pulse, final state IDLE.
REQ-033 Enable gating: one clean press with en=0 at the acceptance edge -> up unchanged and no pulse; next clean press with en=1 -> up toggles and one pulse.
REQ-034 Reset mid-press: up=1, new press held, reset=0 asserted at edge 4 of the press -> up=0; btn_raw still held after reset release -> up=1 at the 6th edge after release.

Source files
------------

// File: rtl/dir_ctrl_pkg.sv
// dir_ctrl_pkg -- shared types and defaults for the direction controller.
//   state_t                 : debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT : default number of stable cycles to accept an edge
package dir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/dir_ctrl_sync.sv
// sync2 -- two-flop synchronizer for a single asynchronous level.
//   clk   : sampling clock
//   reset : synchronous, active-low; clears both flops to 0
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges behind d
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dir_ctrl.sv
// dir_ctrl -- debounced push-button that toggles a direction level.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low
//   btn_raw     : asynchronous bouncy button level, 1 = pressed
//   en          : toggle enable, sampled on the press acceptance edge only
//   up          : registered direction level
//   press_pulse : one-cycle strobe for each accepted press that toggled up
//
// state        | meaning
// IDLE         | button released and debounced
// PRESS_WAIT   | btn_s high, counting stable cycles toward acceptance
// PRESSED      | press accepted, waiting for release
// RELEASE_WAIT | btn_s low, counting stable cycles toward release
module dir_ctrl
  import dir_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic INIT_UP         = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic en,
  output logic up,
  output logic press_pulse
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic          btn_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept;
  logic          up_n, pulse_n;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      up          <= INIT_UP;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      up          <= up_n;
      press_pulse <= pulse_n;
    end
  end

  // ">= CNT_MAX-1" rather than "==" so a corrupted count still terminates
  // instead of wrapping.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= CNT_MAX - CNT_ONE) begin
          state_n = PRESSED;
          cnt_n   = CNT_MAX;
          accept  = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt >= CNT_MAX - CNT_ONE) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    pulse_n = accept & en;
    up_n    = up ^ pulse_n;
  end

endmodule

// File: tb/tb_dir_ctrl.sv
module tb_dir_ctrl;
  import dir_ctrl_pkg::*;

  localparam int   D    = 4;
  localparam logic INIT = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic en = 1'b0;
  logic up, press_pulse;

  always #5 clk = ~clk;

  dir_ctrl #(.DEBOUNCE_CYCLES(D), .INIT_UP(INIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .en          (en),
    .up          (up),
    .press_pulse (press_pulse)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: btn_raw delayed by two edges; a press/release is accepted
  // once the delayed level has disagreed with the debounced level for D
  // consecutive edges.
  logic m_s1 = 0, m_s2 = 0, m_lvl = 0, m_up = INIT, m_pulse = 0;
  int   m_run = 0;

  task automatic model_edge(input logic r, input logic b, input logic e);
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_up = INIT; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl = m_s2;
          m_run = 0;
          if (m_lvl && e) begin
            m_up    = ~m_up;
            m_pulse = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  int pulse_cnt = 0;
  logic prev_pulse = 0;

  task automatic tick(input logic r, input logic b, input logic e);
    @(negedge clk);
    reset = r; btn_raw = b; en = e;
    @(posedge clk);
    model_edge(r, b, e);
    #1;
    chk("mdl_up", up, m_up);
    chk("mdl_pulse", press_pulse, m_pulse);
    if (prev_pulse) chk("pulse_gap", press_pulse, 1'b0);
    prev_pulse = press_pulse;
    if (press_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic hold(input logic r, input logic b, input logic e, input int n);
    for (int i = 0; i < n; i++) tick(r, b, e);
  endtask

  typedef struct {
    logic rst, btn, en, exp_up, exp_pulse;
  } vec_t;
  vec_t tbl[$];

  initial begin
    // Reset, idle, clean press and clean release with fixed expectations.
    for (int i = 0; i < 2; i++)  tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= 12; k++)
      tbl.push_back('{1'b1, 1'b1, 1'b1, logic'(k >= 6), logic'(k == 6)});
    for (int i = 0; i < 12; i++) tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].btn, tbl[i].en);
      chk($sformatf("tbl_up[%0d]", i), up, tbl[i].exp_up);
      chk($sformatf("tbl_pulse[%0d]", i), press_pulse, tbl[i].exp_pulse);
      if (i == 1) chk("rst_state", dut.state, IDLE);
    end

    // Press bounce: never D stable highs in a row.
    hold(1'b0, 1'b0, 1'b1, 2);
    pulse_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      hold(1'b1, 1'b1, 1'b1, 3);
      hold(1'b1, 1'b0, 1'b1, 1);
    end
    hold(1'b1, 1'b0, 1'b1, 8);
    chk("bounce_up", up, 1'b0);
    chk("bounce_pulses", pulse_cnt, 0);

    // Release bounce from PRESSED with up=1.
    hold(1'b1, 1'b1, 1'b1, 12);
    chk("rb_pressed_up", up, 1'b1);
    pulse_cnt = 0;
    hold(1'b1, 1'b0, 1'b1, 2);
    hold(1'b1, 1'b1, 1'b1, 5);
    hold(1'b1, 1'b0, 1'b1, 12);
    chk("rb_up", up, 1'b1);
    chk("rb_pulses", pulse_cnt, 0);
    chk("rb_state", dut.state, IDLE);

    // Enable gating.
    pulse_cnt = 0;
    hold(1'b1, 1'b1, 1'b0, 12);
    hold(1'b1, 1'b0, 1'b0, 12);
    chk("en0_up", up, 1'b1);
    chk("en0_pulses", pulse_cnt, 0);
    hold(1'b1, 1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 1'b1, 12);
    chk("en1_up", up, 1'b0);
    chk("en1_pulses", pulse_cnt, 1);

    // Reset mid-press, button still held afterwards.
    hold(1'b1, 1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 1'b1, 12);
    chk("pre_rst_up", up, 1'b1);
    hold(1'b1, 1'b1, 1'b1, 3);
    tick(1'b0, 1'b1, 1'b1);
    chk("midrst_up", up, 1'b0);
    chk("midrst_state", dut.state, IDLE);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, 1'b1, 1'b1);
      chk($sformatf("after_rst_up[%0d]", k), up, logic'(k >= 6));
    end
    hold(1'b1, 1'b0, 1'b1, 12);

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      logic b, e, r;
      int len;
      b   = 1'($urandom_range(0, 1));
      e   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 59) != 0);
      len = $urandom_range(1, 8);
      if (!r) len = 1;
      hold(r, b, e, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
